// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// classes, opcodes, ALU operations and PC source selects.
package mcu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_JMP, CLS_HALT, CLS_ILL
  } cls_e;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b0101;
  localparam logic [3:0] OP_STORE = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_op_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and legality.
// Any set bit above [3] makes the opcode illegal.
module mcu_op_decode
  import mcu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  output cls_e                cls,
  output logic [2:0]          alu_op,
  output logic                legal
);

  logic hi_nz;

  always_comb begin
    hi_nz = 1'b0;
    for (int unsigned i = 4; i < OPCODE_W; i++) begin
      hi_nz = hi_nz | op[i];
    end

    cls    = CLS_ILL;
    alu_op = ALU_ADD;
    case (op[3:0])
      OP_ADD:   cls = CLS_ALU;
      OP_SUB:   begin cls = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:    begin cls = CLS_ALU; alu_op = ALU_OR;  end
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      OP_BEQ:   begin cls = CLS_BEQ; alu_op = ALU_SUB; end
      OP_JMP:   cls = CLS_JMP;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_ILL;
    endcase
    if (hi_nz) cls = CLS_ILL;

    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle processor control unit: per-class stage paths, memory handshake
// with timeout, sticky status. Define MCU_PERF_CNT_EN for retired/cycle counters.
module multicycle_ctrl_fsm
  import mcu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                en_if,
  output logic                en_id,
  output logic                en_ex,
  output logic                en_mem,
  output logic                en_wb,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_source,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                halted,
  output logic                err_illegal,
  output logic                err_timeout
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    cycle_cnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  if (OPCODE_W < 4 || ALUOP_W < 3 || MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("multicycle_ctrl_fsm: unsupported parameter values");
  end

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                halted_q, halted_d;
  logic                ill_q, ill_d;
  logic                tmo_q, tmo_d;

  // ID decodes the live opcode so JMP/HALT/illegal resolve in that cycle
  logic [OPCODE_W-1:0] dec_op;
  cls_e                dec_cls;
  logic [2:0]          dec_alu;
  logic                dec_legal;
  logic                done;

  assign dec_op = (state_q == S_ID) ? op_code : opcode_q;

  mcu_op_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .op     (dec_op),
    .cls    (dec_cls),
    .alu_op (dec_alu),
    .legal  (dec_legal)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    ill_d    = ill_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        opcode_d = op_code;
        if (!dec_legal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          ill_d    = 1'b1;
        end else if (dec_cls == CLS_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (dec_cls == CLS_JMP) begin
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (dec_cls)
          CLS_ALU:             state_d = S_WB;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          wait_d  = '0;
          state_d = (dec_cls == CLS_LOAD) ? S_WB : S_IF;
        end else if (wait_q == WAIT_LAST) begin
          wait_d   = '0;
          state_d  = S_HALT;
          halted_d = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      opcode_q <= '0;
      wait_q   <= '0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    en_if      = (state_q == S_IF);
    en_id      = (state_q == S_ID);
    en_ex      = (state_q == S_EX);
    en_mem     = (state_q == S_MEM);
    en_wb      = (state_q == S_WB);
    alu_op     = (state_q == S_EX) ? ALUOP_W'(dec_alu) : '0;
    mem_read   = en_mem && (dec_cls == CLS_LOAD);
    mem_write  = en_mem && (dec_cls == CLS_STORE);
    reg_write  = en_wb;
    reg_source = en_wb && (dec_cls == CLS_LOAD);
    done       = 1'b0;
    pc_src     = PC_SEQ;
    case (state_q)
      S_ID: if (dec_legal && dec_cls == CLS_JMP) begin
        done   = 1'b1;
        pc_src = PC_JUMP;
      end
      S_EX: if (dec_cls == CLS_BEQ) begin
        done   = 1'b1;
        pc_src = alu_zero ? PC_BRANCH : PC_SEQ;
      end
      S_MEM:   done = (dec_cls == CLS_STORE) && mem_ready;
      S_WB:    done = 1'b1;
      default: done = 1'b0;
    endcase
    pc_write   = done;
    instr_done = done;
  end

  assign halted      = halted_q;
  assign err_illegal = ill_q;
  assign err_timeout = tmo_q;

`ifdef MCU_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    retired_cnt_d = done ? retired_cnt_q + CNT_W'(1) : retired_cnt_q;
    cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed vector table, corner
// sequences (timeout, illegal, halt, reset mid-wait) and path-model random run.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [4:0] en;   // {if,id,ex,mem,wb}
    logic [2:0] alu;
    logic       mr, mw, rw, rs;
    logic       pw;
    logic [1:0] ps;
    logic       done;
    logic       h, ei, et;
  } out_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  localparam out_t O_IF      = 19'b10000_000_0000_0_00_0_000;
  localparam out_t O_ID      = 19'b01000_000_0000_0_00_0_000;
  localparam out_t O_EX_ADD  = 19'b00100_000_0000_0_00_0_000;
  localparam out_t O_MEM_LD  = 19'b00010_000_1000_0_00_0_000;
  localparam out_t O_MEM_ST  = 19'b00010_000_0100_0_00_0_000;
  localparam out_t O_HALT_OK = 19'b00000_000_0000_0_00_0_100;
  localparam out_t O_HALT_IL = 19'b00000_000_0000_0_00_0_110;
  localparam out_t O_HALT_TO = 19'b00000_000_0000_0_00_0_101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_code = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       en_if, en_id, en_ex, en_mem, en_wb;
  logic [2:0] alu_op;
  logic       mem_read, mem_write, reg_write, reg_source, pc_write, instr_done;
  logic [1:0] pc_src;
  logic       halted, err_illegal, err_timeout;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;
  vec_t tbl[$];
  vec_t stim[$];

  multicycle_ctrl_fsm #(
    .OPCODE_W(4), .ALUOP_W(3), .MEM_TIMEOUT(16), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_source(reg_source), .pc_write(pc_write),
    .pc_src(pc_src), .instr_done(instr_done), .halted(halted),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
`ifdef MCU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] op, input logic z, input logic rdy, input out_t e);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  function automatic out_t cur_out();
    out_t o;
    o.en = {en_if, en_id, en_ex, en_mem, en_wb};
    o.alu = alu_op;
    o.mr = mem_read; o.mw = mem_write; o.rw = reg_write; o.rs = reg_source;
    o.pw = pc_write; o.ps = pc_src; o.done = instr_done;
    o.h = halted; o.ei = err_illegal; o.et = err_timeout;
    return o;
  endfunction

  // Reference model: expand an instruction into its stage path and derive each
  // cycle's inputs and expected outputs from the per-class rules.
  function automatic void gen_instr(input logic [3:0] opc, input logic z, input int unsigned waits);
    string path;
    vec_t  r;
    out_t  e;
    byte   c;
    int unsigned reps;
    logic  last;
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3: path = "FDEW";
      4'h5:    path = "FDEMW";
      4'h6:    path = "FDEM";
      4'h7:    path = "FDE";
      default: path = "FD";
    endcase
    for (int i = 0; i < path.len(); i++) begin
      c = path[i];
      reps = (c == "M") ? waits + 1 : 1;
      for (int unsigned k = 0; k < reps; k++) begin
        last = (i == path.len() - 1) && (k == reps - 1);
        e = '0;
        case (c)
          "F": e.en = 5'b10000;
          "D": e.en = 5'b01000;
          "E": e.en = 5'b00100;
          "M": e.en = 5'b00010;
          default: e.en = 5'b00001;
        endcase
        if (c == "E") e.alu = (opc <= 4'h3) ? opc[2:0] : ((opc == 4'h7) ? 3'b001 : 3'b000);
        if (c == "M") begin e.mr = (opc == 4'h5); e.mw = (opc == 4'h6); end
        if (c == "W") begin e.rw = 1'b1; e.rs = (opc == 4'h5); end
        if (last) begin
          e.pw = 1'b1; e.done = 1'b1;
          e.ps = (opc == 4'h8) ? 2'b10 : ((opc == 4'h7 && z) ? 2'b01 : 2'b00);
        end
        r.op  = (c == "D") ? opc : 4'($urandom);
        r.z   = (c == "E") ? z : 1'($urandom);
        r.rdy = (c == "M") ? (k == reps - 1) : 1'($urandom);
        r.exp = e;
        stim.push_back(r);
      end
    end
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = cur_out();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1: drive, sample on negedge, advance.
  task automatic apply(input vec_t v, input string name);
    op_code = v.op; alu_zero = v.z; mem_ready = v.rdy;
    @(negedge clk);
    check_out(name, v.exp);
    @(posedge clk); #1;
  endtask

  task automatic run_stim(input string tag);
    for (int i = 0; i < stim.size(); i++) apply(stim[i], $sformatf("%s[%0d]", tag, i));
    stim.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_code = 4'($urandom); mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // ADD; LOAD with 3 stalls; BEQ taken/not; JMP; STORE no stall; OR
    tbl.push_back(mk(4'hA, 1'b1, 1'b1, O_IF));
    tbl.push_back(mk(4'h0, 1'b1, 1'b1, O_ID));
    tbl.push_back(mk(4'hC, 1'b1, 1'b0, O_EX_ADD));
    tbl.push_back(mk(4'hC, 1'b0, 1'b0, 19'b00001_000_0010_1_00_1_000));
    tbl.push_back(mk(4'h3, 1'b0, 1'b1, O_IF));
    tbl.push_back(mk(4'h5, 1'b0, 1'b1, O_ID));
    tbl.push_back(mk(4'h0, 1'b1, 1'b1, O_EX_ADD));
    tbl.push_back(mk(4'h6, 1'b1, 1'b0, O_MEM_LD));
    tbl.push_back(mk(4'h6, 1'b1, 1'b0, O_MEM_LD));
    tbl.push_back(mk(4'h6, 1'b1, 1'b0, O_MEM_LD));
    tbl.push_back(mk(4'h6, 1'b1, 1'b1, O_MEM_LD));
    tbl.push_back(mk(4'h6, 1'b0, 1'b0, 19'b00001_000_0011_1_00_1_000));
    tbl.push_back(mk(4'h8, 1'b0, 1'b1, O_IF));
    tbl.push_back(mk(4'h7, 1'b0, 1'b0, O_ID));
    tbl.push_back(mk(4'h8, 1'b1, 1'b0, 19'b00100_001_0000_1_01_1_000));
    tbl.push_back(mk(4'h8, 1'b1, 1'b1, O_IF));
    tbl.push_back(mk(4'h7, 1'b1, 1'b0, O_ID));
    tbl.push_back(mk(4'h8, 1'b0, 1'b1, 19'b00100_001_0000_1_00_1_000));
    tbl.push_back(mk(4'h7, 1'b1, 1'b1, O_IF));
    tbl.push_back(mk(4'h8, 1'b1, 1'b1, 19'b01000_000_0000_1_10_1_000));
    tbl.push_back(mk(4'h5, 1'b0, 1'b0, O_IF));
    tbl.push_back(mk(4'h6, 1'b0, 1'b0, O_ID));
    tbl.push_back(mk(4'h5, 1'b1, 1'b0, O_EX_ADD));
    tbl.push_back(mk(4'h5, 1'b0, 1'b1, 19'b00010_000_0100_1_00_1_000));
    tbl.push_back(mk(4'h0, 1'b1, 1'b0, O_IF));
    tbl.push_back(mk(4'h3, 1'b1, 1'b0, O_ID));
    tbl.push_back(mk(4'h0, 1'b1, 1'b1, 19'b00100_011_0000_0_00_0_000));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 19'b00001_000_0010_1_00_1_000));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // STORE never acknowledged: 16 MEM cycles then sticky timeout
    do_reset();
    stim.push_back(mk(4'h1, 1'b0, 1'b1, O_IF));
    stim.push_back(mk(4'h6, 1'b0, 1'b1, O_ID));
    stim.push_back(mk(4'h2, 1'b1, 1'b1, O_EX_ADD));
    for (int i = 0; i < 16; i++) stim.push_back(mk(4'h6, 1'b1, 1'b0, O_MEM_ST));
    for (int i = 0; i < 3; i++) stim.push_back(mk(4'h0, 1'b0, 1'b1, O_HALT_TO));
    run_stim("timeout");

    // illegal opcode: no pc_write in ID, then halted with err_illegal
    do_reset();
    stim.push_back(mk(4'h0, 1'b0, 1'b1, O_IF));
    stim.push_back(mk(4'hA, 1'b0, 1'b1, O_ID));
    for (int i = 0; i < 3; i++) stim.push_back(mk(4'h8, 1'b1, 1'b1, O_HALT_IL));
    run_stim("illegal");

    // reset clears flags; HALT opcode halts without error
    do_reset();
    gen_instr(4'h1, 1'b0, 0);
    stim.push_back(mk(4'h2, 1'b0, 1'b1, O_IF));
    stim.push_back(mk(4'hF, 1'b0, 1'b1, O_ID));
    for (int i = 0; i < 2; i++) stim.push_back(mk(4'h8, 1'b1, 1'b1, O_HALT_OK));
    run_stim("halt");

    // reset in the middle of a MEM stall, then full-length waits that must not time out
    do_reset();
    stim.push_back(mk(4'h0, 1'b0, 1'b1, O_IF));
    stim.push_back(mk(4'h5, 1'b0, 1'b1, O_ID));
    stim.push_back(mk(4'h0, 1'b0, 1'b1, O_EX_ADD));
    for (int i = 0; i < 10; i++) stim.push_back(mk(4'h5, 1'b0, 1'b0, O_MEM_LD));
    run_stim("memwait");
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    gen_instr(4'h6, 1'b0, 15);
    gen_instr(4'h5, 1'b1, 14);
    gen_instr(4'h0, 1'b0, 0);
    run_stim("rstmid");

    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [3:0] opc;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: opc = 4'(sel);
        4: opc = 4'h5;
        5: opc = 4'h6;
        6: opc = 4'h7;
        default: opc = 4'h8;
      endcase
      gen_instr(opc, 1'($urandom), $urandom_range(0, 8));
    end
    run_stim("rand");

`ifdef MCU_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) gen_instr(4'h0, 1'b0, 0);
    stim.push_back(mk(4'h4, 1'b0, 1'b0, O_IF));
    stim.push_back(mk(4'hF, 1'b0, 1'b0, O_ID));
    stim.push_back(mk(4'h0, 1'b0, 1'b0, O_HALT_OK));
    stim.push_back(mk(4'h0, 1'b0, 1'b0, O_HALT_OK));
    run_stim("perf");
    @(negedge clk);
    check_val("retired_cnt", retired_cnt, 32'd3);
    check_val("cycle_cnt", cycle_cnt, 32'd14);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
